// File: rtl/nibble_sub_seq.sv
// nibble_sub_seq: subtracts two W-bit operands one nibble per cycle by
// driving an external combinational 4-bit full subtractor and collecting
// its difference/borrow back into a result register.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for a request; in_ready high once out of reset
// ST_RUN  | one nibble per cycle through the external subtractor
// ST_DONE | result/borrow_out held with out_valid high until out_ready
module nibble_sub_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 borrow_in,
    output logic [3:0]           sub_a,
    output logic [3:0]           sub_b,
    output logic                 sub_c,
    input  logic [3:0]           sub_diff,
    input  logic                 sub_borrow,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] result,
    output logic                 borrow_out
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [IDX_W-1:0]   nib_idx_q,    nib_idx_d;
    logic               brw_q,        brw_d;
    logic [W-1:0]       a_q,          a_d;
    logic [W-1:0]       b_q,          b_d;
    logic [W-1:0]       result_q,     result_d;
    logic               borrow_out_q, borrow_out_d;
    // Held low by reset so in_ready stays low until the first edge after
    // rst_n is released, even though the state is already IDLE.
    logic               rdy_en_q,     rdy_en_d;

    logic [3:0]         cur_a;
    logic [3:0]         cur_b;
    logic               in_idle;
    logic               in_run;
    logic               accept;
    logic               last_nib;

    assign in_idle  = (state_q == ST_IDLE);
    assign in_run   = (state_q == ST_RUN);
    assign in_ready = in_idle && rdy_en_q;
    assign accept   = in_ready && in_valid;
    assign last_nib = (nib_idx_q == LAST_IDX);

    assign out_valid  = (state_q == ST_DONE);
    assign result     = result_q;
    assign borrow_out = borrow_out_q;

    // Select the operand nibbles addressed by the current index.
    always_comb begin
        cur_a = '0;
        cur_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (nib_idx_q == IDX_W'(i)) begin
                cur_a = a_q[4*i +: 4];
                cur_b = b_q[4*i +: 4];
            end
        end
    end

    // Subtractor operands are only presented while running; zero otherwise.
    always_comb begin
        sub_a = '0;
        sub_b = '0;
        sub_c = 1'b0;
        if (in_run) begin
            sub_a = cur_a;
            sub_b = cur_b;
            sub_c = brw_q;
        end
    end

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d      = state_q;
        nib_idx_d    = nib_idx_q;
        brw_d        = brw_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        borrow_out_d = borrow_out_q;
        rdy_en_d     = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d       = op_a;
                    b_d       = op_b;
                    brw_d     = borrow_in;
                    nib_idx_d = '0;
                    state_d   = ST_RUN;
                end
            end

            ST_RUN: begin
                // The external subtractor is combinational, so its answer
                // for the nibble presented this cycle is captured here.
                for (int i = 0; i < NIBBLES; i++) begin
                    if (nib_idx_q == IDX_W'(i)) begin
                        result_d[4*i +: 4] = sub_diff;
                    end
                end
                brw_d = sub_borrow;
                if (last_nib) begin
                    borrow_out_d = sub_borrow;
                    nib_idx_d    = '0;
                    state_d      = ST_DONE;
                end else begin
                    nib_idx_d = nib_idx_q + IDX_W'(1);
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            nib_idx_q    <= '0;
            brw_q        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            borrow_out_q <= 1'b0;
            rdy_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            nib_idx_q    <= nib_idx_d;
            brw_q        <= brw_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            borrow_out_q <= borrow_out_d;
            rdy_en_q     <= rdy_en_d;
        end
    end

endmodule

// File: tb/tb_nibble_sub_seq.sv
// Bench for nibble_sub_seq: directed corner cases followed by random
// requests, checked against a plain-arithmetic reference model.
module tb_nibble_sub_seq;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         borrow_in;
    logic [3:0]   sub_a;
    logic [3:0]   sub_b;
    logic         sub_c;
    logic [3:0]   sub_diff;
    logic         sub_borrow;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         borrow_out;

    int checks;
    int errors;

    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
    logic         exp_bin;
    logic [W-1:0] exp_res;
    logic         exp_bout;

    nibble_sub_seq #(.NIBBLES(NIBBLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .borrow_in  (borrow_in),
        .sub_a      (sub_a),
        .sub_b      (sub_b),
        .sub_c      (sub_c),
        .sub_diff   (sub_diff),
        .sub_borrow (sub_borrow),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .borrow_out (borrow_out)
    );

    // External combinational 4-bit full subtractor.
    logic [4:0] sub_full;
    assign sub_full   = {1'b0, sub_a} - {1'b0, sub_b} - {4'b0, sub_c};
    assign sub_diff   = sub_full[3:0];
    assign sub_borrow = sub_full[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: whole-word arithmetic.
    task automatic set_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        longint d;
        exp_a    = a;
        exp_b    = b;
        exp_bin  = bin;
        d        = longint'(a) - longint'(b) - longint'(bin);
        exp_res  = d[W-1:0];
        exp_bout = (longint'(a) < longint'(b) + longint'(bin));
    endtask

    function automatic logic [3:0] nib(input logic [W-1:0] v, input int k);
        logic [W-1:0] s;
        s = v >> (4 * k);
        return s[3:0];
    endfunction

    // Borrow into nibble k: the low 4k bits of a fall short of b + bin.
    function automatic logic borrow_into(input int k);
        longint m;
        m = longint'(1) << (4 * k);
        return ((longint'(exp_a) % m) < (longint'(exp_b) % m) + longint'(exp_bin));
    endfunction

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        op_a      = a;
        op_b      = b;
        borrow_in = bin;
        in_valid  = 1'b1;
        chk("in_ready_before_accept", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        set_model(a, b, bin);
    endtask

    // Walk RUN with noisy inputs, then check latency and the result.
    task automatic wait_valid();
        int cnt;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 40) begin
            if (cnt < NIBBLES) begin
                chk("run_sub_a", 32'(sub_a), 32'(nib(exp_a, cnt)));
                chk("run_sub_b", 32'(sub_b), 32'(nib(exp_b, cnt)));
                chk("run_sub_c", 32'(sub_c), 32'(borrow_into(cnt)));
                chk("run_in_ready", 32'(in_ready), 0);
            end
            in_valid  = 1'($urandom_range(0, 1));
            op_a      = W'($urandom);
            op_b      = W'($urandom);
            borrow_in = 1'($urandom);
            tick();
            cnt++;
        end
        chk("latency", 32'(cnt), NIBBLES);
        chk("result", 32'(result), 32'(exp_res));
        chk("borrow_out", 32'(borrow_out), 32'(exp_bout));
    endtask

    task automatic handshake(input bit rand_ready);
        bit hs;
        int n;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 100) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            chk("hold_result", 32'(result), 32'(exp_res));
            chk("hold_borrow_out", 32'(borrow_out), 32'(exp_bout));
            chk("hold_out_valid", 32'(out_valid), 1);
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("done_sub_a_zero", 32'({sub_a, sub_b, sub_c}), 0);
            hs = out_ready;
            tick();
            n++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("handshake_seen", 32'(hs), 1);
        chk("out_valid_after_hs", 32'(out_valid), 0);
        chk("in_ready_after_hs", 32'(in_ready), 1);
    endtask

    task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input bit rand_ready);
        accept(a, b, bin);
        wait_valid();
        handshake(rand_ready);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        borrow_in = 1'b0;
        set_model('0, '0, 1'b0);

        tick();
        tick();
        chk("reset_in_ready", 32'(in_ready), 0);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_result", 32'(result), 0);
        chk("reset_borrow_out", 32'(borrow_out), 0);
        chk("reset_sub_bus", 32'({sub_a, sub_b, sub_c}), 0);

        rst_n = 1'b1;
        chk("in_ready_before_release_edge", 32'(in_ready), 0);
        tick();
        chk("in_ready_after_release", 32'(in_ready), 1);

        do_req(16'h1234, 16'h0034, 1'b0, 1'b0);
        chk("dir1_model", 32'(exp_res), 32'h1200);
        do_req(16'h0000, 16'h0001, 1'b0, 1'b0);
        chk("dir2_model", 32'({exp_bout, exp_res}), 32'h1FFFF);
        do_req(16'h8000, 16'h0000, 1'b1, 1'b0);
        chk("dir3_model", 32'({exp_bout, exp_res}), 32'h07FFF);
        do_req(16'h0000, 16'hFFFF, 1'b1, 1'b0);
        chk("dir4_model", 32'({exp_bout, exp_res}), 32'h10000);

        // Stall in DONE while a new request waits on the input.
        accept(16'h5A5A, 16'h0F0F, 1'b0);
        wait_valid();
        in_valid  = 1'b1;
        op_a      = 16'hABCD;
        op_b      = 16'h1234;
        borrow_in = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("stall_result", 32'(result), 32'(exp_res));
            chk("stall_borrow_out", 32'(borrow_out), 32'(exp_bout));
            chk("stall_out_valid", 32'(out_valid), 1);
            chk("stall_in_ready", 32'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        chk("stall_in_ready_at_hs", 32'(in_ready), 0);
        tick();
        out_ready = 1'b0;
        chk("stall_out_valid_after_hs", 32'(out_valid), 0);
        chk("stall_not_accepted_at_hs", 32'(in_ready), 1);
        accept(16'hABCD, 16'h1234, 1'b1);
        wait_valid();
        handshake(1'b0);

        // Reset during the second RUN cycle aborts the request.
        accept(16'h7777, 16'h1111, 1'b0);
        tick();
        chk("abort_in_run", 32'(out_valid), 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_in_ready_low", 32'(in_ready), 0);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_result_cleared", 32'(result), 0);
        tick();
        chk("abort_in_ready_after_release", 32'(in_ready), 1);
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_out_valid", 32'(out_valid), 0);
            tick();
        end
        do_req(16'h7777, 16'h1111, 1'b0, 1'b0);

        for (int r = 0; r < 200; r++) begin
            do_req(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
